adc_cmd_sequencer: RTL
======================

ADC_CMD_SEQUENCER -- requirements
Module: adc_cmd_sequencer

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 256, cycles spent in WAIT_ACK before a NAK (range 2..65535).
REQ-002 Clock  input  1  system clock; all logic on rising edge.
REQ-003 Reset  input  1  synchronous, active-high.
REQ-004 CmdData  input  8  command byte from host link.
REQ-005 CmdValid  input  1  CmdData valid.
REQ-006 CmdReady  output  1  block accepts a command this cycle.
REQ-007 AdcState  input  4  current state code of the ADC power/control FSM.
REQ-008 adcPwrOn, adcPwrOff, adcSleep, adcWake, adcRunCal  output  1 each  single-cycle command pulses to the ADC FSM.
REQ-009 RespData  output  8  response byte.
REQ-010 RespValid  output  1  RespData valid.
REQ-011 RespReady  input  1  consumer takes the response.
REQ-012 Busy  output  1  high whenever the sequencer is not in IDLE.

Function
REQ-013 The block SHALL be a Moore FSM with states IDLE, CHECK, PULSE, WAIT_ACK, RESPOND.
REQ-014 CmdReady SHALL be high only in IDLE; a command is accepted on the edge where CmdValid and CmdReady are both high, and CmdData is latched then.
REQ-015 CHECK SHALL last exactly one cycle, decode the latched byte, and sample AdcState into a captured-state register.
REQ-016 Command codes: 0x50 power-on (legal when AdcState=0); 0x70 power-off (legal when AdcState=8 or 10); 0x53 sleep (legal when 8); 0x57 wake (legal when 10); 0x43 calibrate (legal when 8); 0x3F status query (always legal).
REQ-017 A legal pulse command SHALL go to PULSE, asserting exactly one matching pulse output for exactly one cycle, two cycles after the accept edge.
REQ-018 Status query SHALL go directly from CHECK to RESPOND with RespData = {4'hA, captured state}; no pulse.
REQ-019 An unknown code SHALL go to RESPOND with 0xEE; a known code that is illegal in the captured state SHALL go to RESPOND with 0xE1; no pulse is issued in either case.
REQ-020 WAIT_ACK SHALL run a timer cleared on entry; if AdcState differs from the captured state, respond 0x06 (ACK); else, after TIMEOUT_CYCLES cycles in WAIT_ACK, respond 0x15 (NAK).
REQ-021 If the state-change check and the timeout occur in the same cycle, ACK SHALL win.
REQ-022 RESPOND SHALL hold RespValid high with RespData stable until RespReady is high, then return to IDLE on that edge; the next command can be accepted one cycle later at the earliest.
REQ-023 Pulse outputs SHALL be registered and mutually exclusive; they are never high outside PULSE.
REQ-024 CmdValid changes outside IDLE SHALL be ignored; no command is queued.

Reset
REQ-025 On Reset the FSM SHALL return to IDLE from any state within one edge, and the timer SHALL clear.
REQ-026 Output values while Reset is high: all pulse outputs 0, RespValid 0, RespData 0x00, Busy 0, CmdReady 0; CmdReady rises in the first cycle after Reset falls.
REQ-027 Reset during WAIT_ACK or RESPOND SHALL discard the pending response without emitting it.

Structure
REQ-028 Package adc_cmd_pkg SHALL hold the command codes, response codes (0x06, 0x15, 0xE1, 0xEE, 0xA status prefix) and the ADC FSM state encodings (ALL_PWR_OFF=0, DES_SAMPLING=8, LOW_PWR_IDLE=10), shared with the ADC FSM.
REQ-029 The block SHALL be a single module with no sub-modules; the timer is an inline counter sized to hold TIMEOUT_CYCLES.

Verification
REQ-030 AdcState=0, send 0x50, model advances state to 1 on the pulse -> adcPwrOn high for 1 cycle two cycles after accept, then RespData 0x06.
REQ-031 AdcState=0, send 0x53 -> no pulse, RespData 0xE1; send 0x12 -> RespData 0xEE.
REQ-032 AdcState=8 held constant, send 0x43 -> adcRunCal pulse once, RespData 0x15 after exactly 256 WAIT_ACK cycles.
REQ-033 AdcState=10, send 0x3F -> RespData 0xAA, no pulse; hold RespReady low 5 cycles -> RespValid and RespData stable, CmdReady low.
REQ-034 Assert Reset during WAIT_ACK -> no response emitted, all outputs at reset values, CmdReady high the cycle after Reset falls.
REQ-035 AdcState changes in the same cycle the timer expires -> RespData 0x06.

Source files
------------

// File: rtl/adc_cmd_pkg.sv
// adc_cmd_pkg
// Shared constants for the ADC command sequencer and the ADC power/control
// FSM: host command codes, response codes, ADC FSM state encodings, the
// sequencer state type and the bit positions of the pulse outputs.
package adc_cmd_pkg;

    // Host command codes
    localparam logic [7:0] CMD_PWR_ON  = 8'h50;
    localparam logic [7:0] CMD_PWR_OFF = 8'h70;
    localparam logic [7:0] CMD_SLEEP   = 8'h53;
    localparam logic [7:0] CMD_WAKE    = 8'h57;
    localparam logic [7:0] CMD_CAL     = 8'h43;
    localparam logic [7:0] CMD_STATUS  = 8'h3F;

    // Response codes
    localparam logic [7:0] RESP_ACK        = 8'h06;
    localparam logic [7:0] RESP_NAK        = 8'h15;
    localparam logic [7:0] RESP_ILLEGAL    = 8'hE1;
    localparam logic [7:0] RESP_UNKNOWN    = 8'hEE;
    localparam logic [3:0] RESP_STATUS_PFX = 4'hA;

    // ADC power/control FSM state encodings
    localparam logic [3:0] ADC_ALL_PWR_OFF  = 4'd0;
    localparam logic [3:0] ADC_DES_SAMPLING = 4'd8;
    localparam logic [3:0] ADC_LOW_PWR_IDLE = 4'd10;

    // Bit positions inside the one-hot pulse vector
    localparam int P_PWR_ON  = 0;
    localparam int P_PWR_OFF = 1;
    localparam int P_SLEEP   = 2;
    localparam int P_WAKE    = 3;
    localparam int P_RUN_CAL = 4;
    localparam int N_PULSE   = 5;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_CHECK,
        SEQ_PULSE,
        SEQ_WAIT_ACK,
        SEQ_RESPOND
    } seq_state_t;

endpackage

// File: rtl/adc_cmd_sequencer.sv
// adc_cmd_sequencer
// Accepts one command byte from the host link, checks it against the current
// ADC FSM state, issues a single-cycle command pulse to the ADC FSM when the
// command is legal, waits for the ADC FSM to change state (ACK) or times out
// (NAK), and returns one response byte.
//
// Ports
//   Clock, Reset          system clock, synchronous active-high reset
//   CmdData/CmdValid      command byte from host, CmdReady high only in IDLE
//   AdcState              current ADC FSM state code
//   adcPwrOn..adcRunCal   registered one-cycle command pulses
//   RespData/RespValid    response byte, held until RespReady
//   Busy                  high whenever not in IDLE
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | CmdReady high, waiting for a command
// CHECK    | decode latched byte, capture AdcState, choose outcome
// PULSE    | exactly one command pulse output is high
// WAIT_ACK | timer runs until AdcState moves (ACK) or times out (NAK)
// RESPOND  | RespValid high, waiting for RespReady
module adc_cmd_sequencer
    import adc_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] CmdData,
    input  logic       CmdValid,
    output logic       CmdReady,
    input  logic [3:0] AdcState,
    output logic       adcPwrOn,
    output logic       adcPwrOff,
    output logic       adcSleep,
    output logic       adcWake,
    output logic       adcRunCal,
    output logic [7:0] RespData,
    output logic       RespValid,
    input  logic       RespReady,
    output logic       Busy
);

    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    seq_state_t           state_q, state_d;
    logic [7:0]           cmd_q;
    logic [3:0]           cap_q;
    logic [TIMER_W-1:0]   timer_q;
    logic [7:0]           resp_q, resp_d;
    logic [N_PULSE-1:0]   pulse_q, pulse_d;

    logic                 cmd_known;
    logic                 cmd_legal;
    logic [N_PULSE-1:0]   pulse_sel;

    // Decode uses the live AdcState: it is only consumed in CHECK, the same
    // cycle the captured-state register samples it, so both see one value.
    always_comb begin
        cmd_known = 1'b1;
        cmd_legal = 1'b0;
        pulse_sel = '0;
        case (cmd_q)
            CMD_PWR_ON: begin
                cmd_legal           = (AdcState == ADC_ALL_PWR_OFF);
                pulse_sel[P_PWR_ON] = 1'b1;
            end
            CMD_PWR_OFF: begin
                cmd_legal            = (AdcState == ADC_DES_SAMPLING) ||
                                       (AdcState == ADC_LOW_PWR_IDLE);
                pulse_sel[P_PWR_OFF] = 1'b1;
            end
            CMD_SLEEP: begin
                cmd_legal          = (AdcState == ADC_DES_SAMPLING);
                pulse_sel[P_SLEEP] = 1'b1;
            end
            CMD_WAKE: begin
                cmd_legal         = (AdcState == ADC_LOW_PWR_IDLE);
                pulse_sel[P_WAKE] = 1'b1;
            end
            CMD_CAL: begin
                cmd_legal            = (AdcState == ADC_DES_SAMPLING);
                pulse_sel[P_RUN_CAL] = 1'b1;
            end
            CMD_STATUS: begin
                cmd_legal = 1'b1;
            end
            default: begin
                cmd_known = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        resp_d  = resp_q;
        pulse_d = '0;
        case (state_q)
            SEQ_IDLE: begin
                if (CmdValid) begin
                    state_d = SEQ_CHECK;
                end
            end
            SEQ_CHECK: begin
                if (!cmd_known) begin
                    state_d = SEQ_RESPOND;
                    resp_d  = RESP_UNKNOWN;
                end else if (!cmd_legal) begin
                    state_d = SEQ_RESPOND;
                    resp_d  = RESP_ILLEGAL;
                end else if (pulse_sel == '0) begin
                    state_d = SEQ_RESPOND;
                    resp_d  = {RESP_STATUS_PFX, AdcState};
                end else begin
                    state_d = SEQ_PULSE;
                    pulse_d = pulse_sel;
                end
            end
            SEQ_PULSE: begin
                state_d = SEQ_WAIT_ACK;
            end
            SEQ_WAIT_ACK: begin
                // State change is tested first so ACK wins a tie with timeout.
                if (AdcState != cap_q) begin
                    state_d = SEQ_RESPOND;
                    resp_d  = RESP_ACK;
                end else if (timer_q == TIMER_LAST) begin
                    state_d = SEQ_RESPOND;
                    resp_d  = RESP_NAK;
                end
            end
            SEQ_RESPOND: begin
                if (RespReady) begin
                    state_d = SEQ_IDLE;
                end
            end
            default: begin
                state_d = SEQ_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= SEQ_IDLE;
            cmd_q   <= 8'h00;
            cap_q   <= 4'h0;
            resp_q  <= 8'h00;
            pulse_q <= '0;
        end else begin
            state_q <= state_d;
            resp_q  <= resp_d;
            pulse_q <= pulse_d;
            if (state_q == SEQ_IDLE && CmdValid) begin
                cmd_q <= CmdData;
            end
            if (state_q == SEQ_CHECK) begin
                cap_q <= AdcState;
            end
        end
    end

    // Timer holds zero outside WAIT_ACK, so it is already clear on entry.
    always_ff @(posedge Clock) begin
        if (Reset || state_q != SEQ_WAIT_ACK) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_q + TIMER_W'(1);
        end
    end

    // Outputs are forced to their reset values for as long as Reset is high,
    // including the cycles after the FSM has already returned to IDLE.
    assign CmdReady  = (state_q == SEQ_IDLE) && !Reset;
    assign Busy      = (state_q != SEQ_IDLE) && !Reset;
    assign RespValid = (state_q == SEQ_RESPOND) && !Reset;
    assign RespData  = RespValid ? resp_q : 8'h00;

    assign adcPwrOn  = pulse_q[P_PWR_ON]  && !Reset;
    assign adcPwrOff = pulse_q[P_PWR_OFF] && !Reset;
    assign adcSleep  = pulse_q[P_SLEEP]   && !Reset;
    assign adcWake   = pulse_q[P_WAKE]    && !Reset;
    assign adcRunCal = pulse_q[P_RUN_CAL] && !Reset;

endmodule
